// File: rtl/shader_pkg.sv
// Shared constants and state encoding for the shader register-file write arbiter.
// Contents: register-file geometry, requester indices, arbiter FSM state type.
// Imported by shader_rf_arbiter and rr_pick.
package shader_pkg;

    localparam int ADDR_W   = 3;   // 8 registers
    localparam int DATA_W   = 16;

    // Requester slots on the write-request vectors; HOST is always the last slot.
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_HOST = 2;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,   // open round-robin arbitration
        ST_HOLD = 1'b1    // locked burst, only the owner may write
    } arb_state_t;

endpackage

// File: rtl/shader_rf_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after i_ptr wins.
// Ports: i_valid (request mask), i_ptr (start index, < N), o_grant (one-hot or zero).
// Zero latency, no state; the caller owns the pointer.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_valid,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_pick;

    // Rotate right so the pointer slot sits at bit 0, take the lowest set bit,
    // then rotate the single winning bit back to its real position.
    assign w_rot   = N'({i_valid, i_valid} >> i_ptr);
    assign w_pick  = w_rot & (~w_rot + N'(1));
    assign o_grant = N'(({w_pick, w_pick} << i_ptr) >> N);

endmodule

// File: rtl/shader_rf_arbiter.sv
// Shader register-file write arbiter: round-robin grant with locked bursts and host override.
// Ports: req_valid/req_lock/req_addr/req_data per requester, host_lock in; req_ready
//   (combinational one-hot grant), registered rf_we/rf_waddr/rf_wdata/grant_id out.
// Build option SHADER_RF_ARB_STATS_EN adds grant_cnt, per-requester saturating transfer counters.
module shader_rf_arbiter
    import shader_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = shader_pkg::ADDR_W,
    parameter int DATA_W   = shader_pkg::DATA_W,
    parameter int MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      host_lock,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [1:0]                grant_id
`ifdef SHADER_RF_ARB_STATS_EN
   ,output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_t         r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_hold_cnt;

    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_xfer;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_idx_next;
    logic [PTR_W-1:0]   w_owner_next;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;
    logic               w_owner_vld;
    logic               w_owner_lock;
    logic               w_hold_last;

    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_rr_gnt)
    );

    // Eligibility: HOLD restricts to the burst owner and ignores host_lock;
    // host_lock in ARB restricts to HOST without consulting the pointer.
    always_comb begin
        w_ready = '0;
        if (r_state == ST_HOLD) begin
            w_ready = req_valid & (NUM_REQ'(1) << r_owner);
        end else if (host_lock) begin
            w_ready = req_valid & (NUM_REQ'(1) << (NUM_REQ - 1));
        end else begin
            w_ready = w_rr_gnt;
        end
    end

    // No grants while reset is held.
    assign req_ready = reset ? w_ready : '0;
    assign w_xfer    = |req_ready;

    // Encode the one-hot grant and mux the winner's write payload.
    always_comb begin
        w_idx  = '0;
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                w_idx  = PTR_W'(i);
                w_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_idx_next   = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + PTR_W'(1);
    assign w_owner_next = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + PTR_W'(1);
    assign w_owner_vld  = req_valid[r_owner];
    assign w_owner_lock = req_lock[r_owner];
    // The grant made this cycle would be the MAX_HOLD-th of the burst.
    assign w_hold_last  = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_xfer) begin
                        // A host-forced grant does not advance the fairness pointer.
                        if (!host_lock) begin
                            r_rr_ptr <= w_idx_next;
                        end
                        if (req_lock[w_idx] && (MAX_HOLD > 1)) begin
                            r_state    <= ST_HOLD;
                            r_owner    <= w_idx;
                            r_hold_cnt <= CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // The owner is still granted in the cycle it drops lock or hits
                    // the burst limit; the burst simply ends after that write.
                    if (w_owner_vld && w_owner_lock && !w_hold_last) begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end else begin
                        r_state    <= ST_ARB;
                        r_hold_cnt <= '0;
                        r_rr_ptr   <= w_owner_next;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    // Registered write port; payload holds its last value while rf_we is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
        end else begin
            rf_we <= w_xfer;
            if (w_xfer) begin
                rf_waddr <= w_addr;
                rf_wdata <= w_data;
                grant_id <= 2'(w_idx);
            end
        end
    end

`ifdef SHADER_RF_ARB_STATS_EN
    logic [15:0] r_grant_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_cnt[g*16 +: 16] = r_grant_cnt[g];
    end
`endif

endmodule

// File: doc/shader_rf_arbiter.md
SHADER_RF_ARBITER -- requirements
Module: shader_rf_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 3, number of write requesters (ALU=0, LOAD=1, HOST=NUM_REQ-1).
REQ-002 Parameter: ADDR_W, 3, register-file address width (8 registers).
REQ-003 Parameter: DATA_W, 16, register data width.
REQ-004 Parameter: MAX_HOLD, 4, maximum consecutive grants per locked burst.
REQ-005 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-low reset.
REQ-007 Port: req_valid  input  NUM_REQ  per-requester write request.
REQ-008 Port: req_lock  input  NUM_REQ  per-requester burst-hold request.
REQ-009 Port: req_addr  input  NUM_REQ*ADDR_W  packed destination addresses, requester i at slice i.
REQ-010 Port: req_data  input  NUM_REQ*DATA_W  packed write data, requester i at slice i.
REQ-011 Port: host_lock  input  1  restricts grants to HOST while high.
REQ-012 Port: req_ready  output  NUM_REQ  one-hot-or-zero combinational grant.
REQ-013 Port: rf_we, rf_waddr, rf_wdata  output  1/ADDR_W/DATA_W  registered register-file write port.
REQ-014 Port: grant_id  output  2  registered index of requester driving the current rf_we.

Function
REQ-015 Handshake: transfer on req_valid[i] & req_ready[i]; at most one req_ready bit high per cycle.
REQ-016 Latency: transfer in cycle N -> rf_we=1 with that addr/data and grant_id=i in cycle N+1; rf_we=0 in any cycle following a cycle with no transfer.
REQ-017 FSM states: ARB, HOLD.
REQ-018 ARB: round-robin among valid requesters starting at pointer rr_ptr; winner gets req_ready.
REQ-019 After an ARB grant to i: rr_ptr <= (i+1) mod NUM_REQ; no grant -> rr_ptr unchanged.
REQ-020 ARB -> HOLD when the granted requester has req_lock=1 at the transfer; owner and hold_cnt=1 recorded.
REQ-021 HOLD: only owner eligible; owner valid -> grant, hold_cnt increments.
REQ-022 HOLD -> ARB when owner req_lock=0, owner req_valid=0 (no grant that cycle), or the grant making hold_cnt reach MAX_HOLD; rr_ptr = owner+1 on exit.
REQ-023 host_lock=1 in ARB: only HOST eligible, other req_ready=0, rr_ptr unchanged; host_lock ignored in HOLD until exit.
REQ-024 Same-address requests from several requesters in one cycle: only the winner granted; losers stall, no merging.
REQ-025 req_ready is combinational from req_valid, req_lock, host_lock, state, rr_ptr; no dependence on req_addr/req_data.

Reset
REQ-026 reset low asynchronously forces: state=ARB, rr_ptr=0, hold_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, all counters 0.
REQ-027 req_ready=0 while reset low; a write in flight at reset assertion is dropped.
REQ-028 First grant possible in the first rising edge after reset deasserts.

Configuration
REQ-029 Macro SHADER_RF_ARB_STATS_EN defined: output grant_cnt (NUM_REQ*16) adds per-requester 16-bit saturating transfer counters (hold at 16'hFFFF).
REQ-030 Macro undefined: grant_cnt port and counters absent; all other behaviour identical.

Structure
REQ-031 Shared package shader_pkg holds ADDR_W, DATA_W, requester index constants (REQ_ALU, REQ_LOAD, REQ_HOST) and the ARB/HOLD state enum.
REQ-032 One sub-module rr_pick: combinational round-robin picker (valid mask, pointer -> one-hot grant).

Verification
REQ-033 After reset, ALU writes addr 0 data 4, LOAD addr 1 data 3 same cycle -> ALU granted first; rf_we cycles N+1 (0,4) and N+2 (1,3).
REQ-034 All three valid continuously, no lock -> grant order 0,1,2,0,1,2; rr_ptr wraps.
REQ-035 LOAD asserts req_lock with 6 back-to-back requests -> 4 consecutive LOAD grants, then HOST (next in round robin) granted.
REQ-036 host_lock=1 with ALU and HOST valid -> only HOST writes; ALU req_ready stays 0 until host_lock drops.
REQ-037 reset asserted mid-burst in HOLD -> rf_we=0 immediately, state ARB, next grant after deassertion starts at requester 0.
REQ-038 With SHADER_RF_ARB_STATS_EN, 70000 ALU transfers -> grant_cnt for ALU = 16'hFFFF.
